id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage of the MIPS pipeline. It captures the two operands the register file drives out on the falling edge, together with the decoded instruction fields, into the ID/EX pipeline register. It also detects load-use hazards, inserts bubbles, honours branch flushes and multi-cycle execute holds, and drives the stall enables back to the PC and IF/ID register.

## Interface
Parameters:
- CTRL_W, 8, width of decoded control bundle
- STALL_CNT_W, 32, width of stall performance counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_rs, id_rt, id_wreg  in  5 each  source regs / destination reg
- id_uses_rs, id_uses_rt  in  1 each  instruction actually reads rs / rt
- id_read_data1, id_read_data2  in  32 each  register-file operands, stable before rising edge
- id_imm  in  32  sign-extended immediate
- id_pc4  in  32  PC+4 of decode instruction
- id_ctrl  in  CTRL_W  decoded controls; bit CTRL_MEM_READ = load, bit CTRL_REG_WRITE = writes reg
- ex_busy  in  1  multi-cycle execute unit cannot accept a new op
- flush  in  1  branch/jump taken; kill decode slot
- pc_write, if_id_write  out  1 each  upstream enables; 0 = hold
- ex_valid  out  1  ID/EX slot valid
- ex_rs, ex_rt, ex_wreg  out  5 each
- ex_data1, ex_data2, ex_imm, ex_pc4  out  32 each
- ex_ctrl  out  CTRL_W
- stall_cnt  out  STALL_CNT_W  (only with macro)

## Operation
- Hazard (combinational): load_use = id_valid & ex_valid & ex_ctrl[CTRL_MEM_READ] & ex_wreg!=0 & ((id_uses_rs & id_rs==ex_wreg) | (id_uses_rt & id_rt==ex_wreg)).
- FSM states: RUN, LU_STALL, HOLD.
- RUN:
  - ex_busy -> HOLD.
  - Otherwise load_use -> LU_STALL.
  - Otherwise stay.
- LU_STALL:
  - Lasts exactly one cycle. The bubble has entered EX, so load_use deasserts.
  - Returns to RUN, or goes to HOLD if ex_busy.
- HOLD:
  - Stays while ex_busy.
  - Goes to RUN when ex_busy falls.
- Per-cycle action at rising edge, priority order:
  - rst: all state cleared.
  - flush: ex_valid<=0, ex_ctrl<=CTRL_NOP. Other ex fields are don't-care but held. State goes to RUN, or to HOLD if ex_busy.
  - ex_busy: ID/EX register holds all fields.
  - load_use: bubble, i.e. ex_valid<=0, ex_ctrl<=CTRL_NOP, ex_wreg<=0.
  - Else: capture all id_* fields; ex_valid<=id_valid.
- Invalid decode slot (id_valid=0): captured with ex_ctrl forced to CTRL_NOP.
- pc_write = if_id_write = ~(ex_busy | load_use) | flush. Flush must always let the fetch redirect proceed.
- Destination reg 0: never creates a hazard.

## Timing
- Reset values:
  - ex_valid=0, ex_ctrl=CTRL_NOP, all ex data/reg fields 0.
  - State RUN.
  - stall_cnt=0.
  - pc_write=if_id_write=1 while in reset (no hazard possible since ex_valid=0).
- Latency: id_* to ex_* is 1 cycle.
- pc_write/if_id_write are combinational from current inputs and ex_* registers, with no register delay.
- A load followed immediately by a dependent instruction loses exactly 1 cycle. The dependent instruction enters EX 2 cycles after the load.
- Flush coinciding with load_use: flush wins, no bubble counted, enables stay 1.
- Flush coinciding with ex_busy: the ID/EX slot is nulled anyway. The busy unit's own operation is not part of this register.
- Reset asserted mid-stall: next cycle is RUN with an empty slot.

## Configuration
- STALL_CNT_EN:
  - Defined: stall_cnt increments by 1 every cycle in which pc_write=0. It wraps modulo 2^STALL_CNT_W and clears on rst.
  - Undefined: the stall_cnt port and counter logic are absent. All other behaviour is identical.

## Structure
- pipeline_pkg holds:
  - CTRL_W default
  - CTRL_MEM_READ, CTRL_REG_WRITE bit indices
  - CTRL_NOP constant
  - FSM state enum (RUN, LU_STALL, HOLD)
- Sub-module hazard_detect: purely combinational load_use comparator, reusable by the forwarding unit.

## Test plan
- Reset: rst=1 for 2 cycles, then check ex_valid=0, ex_ctrl=CTRL_NOP, pc_write=1, stall_cnt=0.
- Pass-through: id_valid=1, id_read_data1=3, id_read_data2=5, id_rs=1, id_rt=3. Next cycle ex_data1=3, ex_data2=5, ex_valid=1, no stall.
- Load-use:
  - Stimulus: lw $2 (ex_wreg=2, MEM_READ) followed by add with id_rs=2.
  - Required response: pc_write=0 for 1 cycle, one bubble (ex_valid=0), then the add is captured. stall_cnt=1.
- Dependency on $0: a load to $0 followed by a reader of $0 produces no stall.
- Hold: ex_busy=1 for 3 cycles. ex_* is frozen and pc_write=0 for 3 cycles (stall_cnt=3). The next instruction is captured on the cycle ex_busy falls.
- Flush with hazard: flush=1 in the same cycle as load_use. ex_valid=0, pc_write=1, stall_cnt unchanged, state RUN.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared MIPS pipeline definitions: decoded-control layout, the NOP bundle
// and the ID/EX stage sequencing states.
package pipeline_pkg;

  localparam int CTRL_W_DEFAULT = 8;
  localparam int CTRL_MEM_READ  = 0;
  localparam int CTRL_REG_WRITE = 1;

  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_NOP = 8'h00;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    HOLD     = 2'd2
  } stage_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags a decode instruction that reads the destination
// of a load currently sitting in EX. Register 0 never produces a hazard.
module hazard_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_wreg,
  output logic       load_use
);

  logic rs_match_s;
  logic rt_match_s;

  assign rs_match_s = id_uses_rs & (id_rs == ex_wreg);
  assign rt_match_s = id_uses_rt & (id_rt == ex_wreg);

  assign load_use = id_valid & ex_valid & ex_mem_read & (ex_wreg != 5'd0)
                  & (rs_match_s | rt_match_s);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbling, flush and execute-hold.
// Optional macro STALL_CNT_EN adds a stall_cnt port counting pc_write=0 cycles.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int CTRL_W      = pipeline_pkg::CTRL_W_DEFAULT,
  parameter int STALL_CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_wreg,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [31:0]       id_read_data1,
  input  logic [31:0]       id_read_data2,
  input  logic [31:0]       id_imm,
  input  logic [31:0]       id_pc4,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_busy,
  input  logic              flush,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_wreg,
  output logic [31:0]       ex_data1,
  output logic [31:0]       ex_data2,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_pc4,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(CTRL_NOP);

  stage_state_e state_r;
  stage_state_e state_next_s;
  logic         load_use_s;
  logic         stall_s;

  hazard_detect u_hazard (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
    .ex_wreg     (ex_wreg),
    .load_use    (load_use_s)
  );

  // A taken branch must always be allowed to redirect fetch.
  assign stall_s     = (ex_busy | load_use_s) & ~flush;
  assign pc_write    = ~stall_s;
  assign if_id_write = ~stall_s;

  // Next-state: busy dominates, a load-use stall lasts a single cycle.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ex_busy ? HOLD : RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (ex_busy) begin
            state_next_s = HOLD;
          end else if (load_use_s) begin
            state_next_s = LU_STALL;
          end else begin
            state_next_s = RUN;
          end
        end
        LU_STALL: state_next_s = ex_busy ? HOLD : RUN;
        HOLD:     state_next_s = ex_busy ? HOLD : RUN;
        default:  state_next_s = RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // ID/EX register: reset, flush, hold, bubble, capture in priority order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_rs    <= 5'd0;
      ex_rt    <= 5'd0;
      ex_wreg  <= 5'd0;
      ex_data1 <= 32'd0;
      ex_data2 <= 32'd0;
      ex_imm   <= 32'd0;
      ex_pc4   <= 32'd0;
      ex_ctrl  <= NOP_CTRL;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= NOP_CTRL;
    end else if (ex_busy) begin
      ex_valid <= ex_valid;
    end else if (load_use_s) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= NOP_CTRL;
      ex_wreg  <= 5'd0;
    end else begin
      ex_valid <= id_valid;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_wreg  <= id_wreg;
      ex_data1 <= id_read_data1;
      ex_data2 <= id_read_data2;
      ex_imm   <= id_imm;
      ex_pc4   <= id_pc4;
      ex_ctrl  <= id_valid ? id_ctrl : NOP_CTRL;
    end
  end

`ifdef STALL_CNT_EN
  // Stall performance counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= {STALL_CNT_W{1'b0}};
    end else if (stall_s) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each driven cycle pushes the expected
// ID/EX contents, which are popped and compared after the rising edge.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam logic [7:0] LW_C  = 8'h03;
  localparam logic [7:0] ADD_C = 8'h02;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_wreg;
  logic        id_uses_rs, id_uses_rt;
  logic [31:0] id_read_data1, id_read_data2, id_imm, id_pc4;
  logic [7:0]  id_ctrl;
  logic        ex_busy, flush;
  logic        pc_write, if_id_write, ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_wreg;
  logic [31:0] ex_data1, ex_data2, ex_imm, ex_pc4;
  logic [7:0]  ex_ctrl;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(8), .STALL_CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_wreg(id_wreg), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_imm(id_imm), .id_pc4(id_pc4), .id_ctrl(id_ctrl), .ex_busy(ex_busy),
    .flush(flush), .pc_write(pc_write), .if_id_write(if_id_write),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_pc4(ex_pc4), .ex_ctrl(ex_ctrl)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, wreg;
    logic [31:0] d1, d2, imm, pc4;
    logic [7:0]  ctrl;
  } exp_t;

  typedef enum int { K_CAP, K_BUB, K_HOLD, K_FLUSH, K_RST } kind_e;

  exp_t        sb_q[$];
  exp_t        last_exp;
  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [31:0] exp_stall    = 32'd0;
  logic [31:0] pc_seq       = 32'd0;
  logic        uses_rt_g    = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL sb_empty: got no expected entry, required one");
      return;
    end
    e = sb_q.pop_front();
    check_eq("ex_valid", 32'(ex_valid), 32'(e.valid));
    check_eq("ex_rs",    32'(ex_rs),    32'(e.rs));
    check_eq("ex_rt",    32'(ex_rt),    32'(e.rt));
    check_eq("ex_wreg",  32'(ex_wreg),  32'(e.wreg));
    check_eq("ex_data1", ex_data1, e.d1);
    check_eq("ex_data2", ex_data2, e.d2);
    check_eq("ex_imm",   ex_imm,   e.imm);
    check_eq("ex_pc4",   ex_pc4,   e.pc4);
    check_eq("ex_ctrl",  32'(ex_ctrl), 32'(e.ctrl));
`ifdef STALL_CNT_EN
    check_eq("stall_cnt", stall_cnt, exp_stall);
`endif
  endtask

  // One pipeline cycle: drive at negedge, check enables, push expectation, compare after posedge.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] wreg, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [7:0] ctl, input logic busy, input logic fl, input logic r,
                      input logic exp_pc, input kind_e kind);
    exp_t e;
    @(negedge clk);
    pc_seq        = pc_seq + 32'd4;
    id_valid      = v;
    id_rs         = rs;
    id_rt         = rt;
    id_wreg       = wreg;
    id_read_data1 = d1;
    id_read_data2 = d2;
    id_imm        = d1 ^ 32'h0000_ff00;
    id_pc4        = pc_seq;
    id_ctrl       = ctl;
    id_uses_rs    = 1'b1;
    id_uses_rt    = uses_rt_g;
    ex_busy       = busy;
    flush         = fl;
    rst           = r;
    #1;
    if (kind != K_RST) begin
      check_eq("pc_write",    32'(pc_write),    32'(exp_pc));
      check_eq("if_id_write", 32'(if_id_write), 32'(exp_pc));
    end
    e = last_exp;
    case (kind)
      K_CAP: begin
        e.valid = v;      e.rs = rs;          e.rt = rt;    e.wreg = wreg;
        e.d1    = d1;     e.d2 = d2;          e.imm = d1 ^ 32'h0000_ff00;
        e.pc4   = pc_seq; e.ctrl = v ? ctl : 8'h00;
      end
      K_BUB:   begin e.valid = 1'b0; e.ctrl = 8'h00; e.wreg = 5'd0; end
      K_HOLD:  begin end
      K_FLUSH: begin e.valid = 1'b0; e.ctrl = 8'h00; end
      K_RST:   e = '0;
      default: begin end
    endcase
    if (kind == K_RST) exp_stall = 32'd0;
    else if (!exp_pc)  exp_stall = exp_stall + 32'd1;
    sb_q.push_back(e);
    last_exp = e;
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_wreg = 5'd0;
    id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_read_data1 = 32'd0; id_read_data2 = 32'd0;
    id_imm = 32'd0; id_pc4 = 32'd0; id_ctrl = 8'h00; ex_busy = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("rst_ex_ctrl",  32'(ex_ctrl),  32'(CTRL_NOP));
    check_eq("rst_pc_write", 32'(pc_write), 32'd1);
    check_eq("rst_ex_data1", ex_data1, 32'd0);
    check_eq("rst_ex_wreg",  32'(ex_wreg), 32'd0);
`ifdef STALL_CNT_EN
    check_eq("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    last_exp = '0;

    // Pass-through
    step(1'b1, 5'd1, 5'd3, 5'd4, 32'd3, 32'd5, ADD_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    // Load-use on rs: one bubble, then the add is captured
    step(1'b1, 5'd1, 5'd7, 5'd2, 32'h100, 32'h0, LW_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    step(1'b1, 5'd2, 5'd5, 5'd6, 32'h11, 32'h22, ADD_C, 1'b0, 1'b0, 1'b0, 1'b0, K_BUB);
    step(1'b1, 5'd2, 5'd5, 5'd6, 32'h11, 32'h22, ADD_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    // Load-use on rt
    step(1'b1, 5'd1, 5'd4, 5'd9, 32'h200, 32'h0, LW_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    step(1'b1, 5'd3, 5'd9, 5'd10, 32'h33, 32'h44, ADD_C, 1'b0, 1'b0, 1'b0, 1'b0, K_BUB);
    step(1'b1, 5'd3, 5'd9, 5'd10, 32'h33, 32'h44, ADD_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    // Load to $0 then reader of $0: no stall
    step(1'b1, 5'd1, 5'd2, 5'd0, 32'h300, 32'h0, LW_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    step(1'b1, 5'd0, 5'd0, 5'd7, 32'h55, 32'h66, ADD_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    // rt matches but is not read: no stall
    step(1'b1, 5'd1, 5'd2, 5'd8, 32'h400, 32'h0, LW_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    uses_rt_g = 1'b0;
    step(1'b1, 5'd1, 5'd8, 5'd11, 32'h77, 32'h88, ADD_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    uses_rt_g = 1'b1;
    // Execute hold for 3 cycles, then capture as busy falls
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd5, 5'd6, 5'd12, 32'h500 + 32'(i), 32'h9, ADD_C, 1'b1, 1'b0, 1'b0, 1'b0, K_HOLD);
    step(1'b1, 5'd5, 5'd6, 5'd12, 32'h5ff, 32'h9, ADD_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    // Flush coinciding with load-use
    step(1'b1, 5'd1, 5'd2, 5'd3, 32'h600, 32'h0, LW_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    step(1'b1, 5'd3, 5'd1, 5'd13, 32'haa, 32'hbb, ADD_C, 1'b0, 1'b1, 1'b0, 1'b1, K_FLUSH);
    step(1'b1, 5'd3, 5'd1, 5'd13, 32'hcc, 32'hdd, ADD_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    // Invalid decode slot carries a load control but is captured as NOP
    step(1'b0, 5'd1, 5'd2, 5'd14, 32'h700, 32'h1, LW_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    step(1'b1, 5'd14, 5'd14, 5'd15, 32'h710, 32'h2, ADD_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    // Flush coinciding with busy, then busy persists, then releases
    step(1'b1, 5'd1, 5'd2, 5'd17, 32'h800, 32'h3, ADD_C, 1'b1, 1'b1, 1'b0, 1'b1, K_FLUSH);
    step(1'b1, 5'd1, 5'd2, 5'd17, 32'h810, 32'h3, ADD_C, 1'b1, 1'b0, 1'b0, 1'b0, K_HOLD);
    step(1'b1, 5'd1, 5'd2, 5'd17, 32'h820, 32'h3, ADD_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    // Reset asserted while a load-use stall is pending
    step(1'b1, 5'd1, 5'd2, 5'd5, 32'h900, 32'h0, LW_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);
    step(1'b1, 5'd5, 5'd0, 5'd16, 32'h910, 32'h4, ADD_C, 1'b0, 1'b0, 1'b1, 1'b0, K_RST);
    step(1'b1, 5'd5, 5'd0, 5'd16, 32'h920, 32'h4, ADD_C, 1'b0, 1'b0, 1'b0, 1'b1, K_CAP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
